// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
// Shared types and helpers for the bus arbiter family.
//   state_e : FSM encoding (ST_IDLE, ST_GRANT, ST_RELEASE), visible on the debug port
//   clog2   : ceiling log2 used to size counters and pointers (never below 1 bit)
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
// Bundles the request side (NUM_MST masters) and the shared slave channel.
//   m_valid/m_data/m_ready : per-master request, packed data, completion strobe
//   s_valid/s_data/s_ready : shared slave channel
//   grant/busy/timeout_err : arbiter status
// Handshake: a word moves when valid and ready are both high on a rising edge.
// A master holds m_valid and its m_data slice stable until its m_ready pulse;
// the arbiter holds s_valid and s_data stable until s_ready or an abort.
// modport master : the arbiter's own view (it masters the slave channel)
// modport slave  : the surrounding environment's view
interface bus_arbiter_if #(
   parameter int NUM_MST = 4,
   parameter int WIDTH   = 4
);
   logic [NUM_MST-1:0]       m_valid;
   logic [NUM_MST*WIDTH-1:0] m_data;
   logic [NUM_MST-1:0]       m_ready;
   logic                     s_valid;
   logic [WIDTH-1:0]         s_data;
   logic                     s_ready;
   logic [NUM_MST-1:0]       grant;
   logic                     busy;
   logic                     timeout_err;

   modport master (
      input  m_valid, m_data, s_ready,
      output m_ready, s_valid, s_data, grant, busy, timeout_err
   );

   modport slave (
      output m_valid, m_data, s_ready,
      input  m_ready, s_valid, s_data, grant, busy, timeout_err
   );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// bus_arbiter_rr_pick
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
//   req_i : request vector
//   ptr_i : search start index (expected < NUM_MST)
//   gnt_o : one-hot winner, zero when no request
//   idx_o : binary index of the winner
//   any_o : at least one request present
module bus_arbiter_rr_pick #(
   parameter int NUM_MST = 4,
   parameter int PW      = 2
) (
   input  logic [NUM_MST-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   output logic [NUM_MST-1:0] gnt_o,
   output logic [PW-1:0]      idx_o,
   output logic               any_o
);

   always_comb begin
      int   cand;
      logic found;
      cand  = 0;
      found = 1'b0;
      gnt_o = '0;
      idx_o = '0;
      for (int off = 0; off < NUM_MST; off++) begin
         cand = int'(ptr_i) + off;
         if (cand >= NUM_MST) cand = cand - NUM_MST;
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = PW'(cand);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter sharing one valid/ready slave channel among NUM_MST
// masters. One grant at a time; after every grant a GAP-cycle idle window lets
// the slave's pipelined ready drain. A watchdog aborts a grant that the slave
// never answers within TIMEOUT cycles.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : bus_arbiter_if.master (requests, slave channel, status)
//   dbg_state_o : current FSM state
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_MST = 4,
   parameter int WIDTH   = 4,
   parameter int GAP     = 2,
   parameter int TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rst,
   bus_arbiter_if.master  bus,
   output state_e         dbg_state_o
);

   localparam int PW  = clog2(NUM_MST);
   localparam int WDW = clog2(TIMEOUT + 1);
   localparam int GW  = clog2(GAP + 1);

   state_e             state_q, state_d;
   logic [NUM_MST-1:0] grant_q, grant_d;
   logic [PW-1:0]      gidx_q, gidx_d;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [WDW-1:0]     wd_cnt_q, wd_cnt_d;
   logic [GW-1:0]      gap_cnt_q, gap_cnt_d;

   logic [NUM_MST-1:0] pick_gnt;
   logic [PW-1:0]      pick_idx;
   logic               pick_any;
   logic               timeout_pulse;
   logic [WIDTH-1:0]   s_data_mux;

   bus_arbiter_rr_pick #(
      .NUM_MST (NUM_MST),
      .PW      (PW)
   ) u_pick (
      .req_i (bus.m_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         gidx_q    <= '0;
         rr_ptr_q  <= '0;
         wd_cnt_q  <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gidx_q    <= gidx_d;
         rr_ptr_q  <= rr_ptr_d;
         wd_cnt_q  <= wd_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   always_comb begin
      logic end_grant;
      state_d       = state_q;
      grant_d       = grant_q;
      gidx_d        = gidx_q;
      rr_ptr_d      = rr_ptr_q;
      wd_cnt_d      = wd_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      timeout_pulse = 1'b0;
      end_grant     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d  = ST_GRANT;
               grant_d  = pick_gnt;
               gidx_d   = pick_idx;
               wd_cnt_d = '0;
            end
         end
         ST_GRANT: begin
            // Completion wins over a same-cycle drop or watchdog expiry.
            if (bus.s_ready) begin
               end_grant = 1'b1;
            end else if (!bus.m_valid[gidx_q]) begin
               end_grant = 1'b1;
            end else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
               end_grant     = 1'b1;
               timeout_pulse = 1'b1;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
            if (end_grant) begin
               state_d   = ST_RELEASE;
               grant_d   = '0;
               gap_cnt_d = '0;
               rr_ptr_d  = (gidx_q == PW'(NUM_MST - 1)) ? '0 : gidx_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            if (gap_cnt_q == GW'(GAP - 1)) begin
               state_d   = ST_IDLE;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // grant_q is only non-zero in GRANT, so the mux and m_ready go quiet elsewhere
   // and any late s_ready during RELEASE cannot leak through.
   always_comb begin
      s_data_mux = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (grant_q[i]) s_data_mux = s_data_mux | bus.m_data[i*WIDTH +: WIDTH];
      end
   end

   assign bus.s_data      = s_data_mux;
   assign bus.s_valid     = (state_q == ST_GRANT);
   assign bus.m_ready     = grant_q & {NUM_MST{bus.s_ready}};
   assign bus.grant       = grant_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.timeout_err = timeout_pulse;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Directed bench for bus_arbiter with NUM_MST=4, WIDTH=4, GAP=2, TIMEOUT=15.
// A slave model registers s_valid once and returns ready one cycle later.
// A behavioural model tracks owner / grant age / gap cycles left / rr pointer
// and predicts every output each cycle; literal checks pin the model.
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   localparam int N   = 4;
   localparam int W   = 4;
   localparam int GAP = 2;
   localparam int TO  = 15;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   bus_arbiter_if #(.NUM_MST(N), .WIDTH(W)) bus ();
   state_e dbg_state;

   bus_arbiter #(
      .NUM_MST (N),
      .WIDTH   (W),
      .GAP     (GAP),
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- master driver ----------------
   // Master i keeps requesting while done_cnt[i] < want[i].
   logic [W-1:0] mdata [N] = '{default: '0};
   int           want  [N] = '{default: 0};
   int           done_cnt [N] = '{default: 0};

   always begin
      logic [N-1:0] fired;
      @(negedge clk);
      fired = bus.m_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (fired[i]) done_cnt[i]++;
         bus.m_valid[i]       = (done_cnt[i] < want[i]);
         bus.m_data[i*W +: W] = mdata[i];
      end
   end

   // ---------------- slave model ----------------
   logic         v1_q, rdy_q;
   logic         slave_on;
   logic [W-1:0] cap_q [$];

   always @(posedge clk) begin
      if (!rst && bus.s_valid === 1'b1 && bus.s_ready === 1'b1) cap_q.push_back(bus.s_data);
      if (rst) begin
         v1_q  <= 1'b0;
         rdy_q <= 1'b0;
      end else begin
         v1_q  <= bus.s_valid;
         rdy_q <= v1_q;
      end
   end
   assign bus.s_ready = slave_on & rdy_q;

   // ---------------- model + scoreboard ----------------
   int           owner    = -1;
   int           age      = 0;
   int           gap_left = 0;
   int           rr       = 0;
   bit           chk_en   = 1'b0;
   logic [W-1:0] exp_q [$];
   logic [W-1:0] log_q [$];

   always @(negedge clk) begin
      logic [N-1:0] e_grant, e_mready;
      logic [W-1:0] e_data;
      logic         e_to;
      logic [W-1:0] got;
      bit           end_now;
      if (chk_en) begin
         e_grant  = '0;
         e_mready = '0;
         e_data   = '0;
         e_to     = 1'b0;
         if (owner >= 0) begin
            e_grant[owner] = 1'b1;
            e_data         = bus.m_data[owner*W +: W];
            if (bus.s_ready) e_mready[owner] = 1'b1;
            else if (bus.m_valid[owner] && age + 1 == TO) e_to = 1'b1;
         end
         check("grant", 32'(bus.grant), 32'(e_grant));
         check("s_valid", 32'(bus.s_valid), 32'(owner >= 0));
         check("s_data", 32'(bus.s_data), 32'(e_data));
         check("m_ready", 32'(bus.m_ready), 32'(e_mready));
         check("busy", 32'(bus.busy), 32'(owner >= 0 || gap_left > 0));
         check("timeout_err", 32'(bus.timeout_err), 32'(e_to));
         while (cap_q.size() > 0) begin
            got = cap_q.pop_front();
            log_q.push_back(got);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL capture: got %0h expected no word", got);
            end else begin
               check("capture", 32'(got), 32'(exp_q.pop_front()));
            end
         end
      end
      end_now = 1'b0;
      if (rst) begin
         owner = -1; age = 0; gap_left = 0; rr = 0;
         exp_q.delete();
      end else if (owner >= 0) begin
         if (bus.s_ready) begin
            exp_q.push_back(bus.m_data[owner*W +: W]);
            end_now = 1'b1;
         end else if (!bus.m_valid[owner] || age + 1 == TO) begin
            end_now = 1'b1;
         end else begin
            age++;
         end
         if (end_now) begin
            rr       = (owner + 1) % N;
            owner    = -1;
            gap_left = GAP;
         end
      end else if (gap_left > 0) begin
         gap_left--;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (owner < 0 && bus.m_valid[(rr + k) % N]) owner = (rr + k) % N;
         end
         age = 0;
      end
   end

   // ---------------- test helpers ----------------
   int t;
   int gc [$];
   int gi [$];

   task automatic tick();
      @(negedge clk);
      t++;
   endtask

   task automatic start();
      @(negedge clk);
      t = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_slave(input logic v);
      @(posedge clk);
      #2 slave_on = v;
      @(negedge clk);
   endtask

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   function automatic bit all_done();
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < N; i++) if (done_cnt[i] < want[i]) ok = 1'b0;
      return ok;
   endfunction

   // Records (cycle, master) of every new grant; optionally adds one request
   // for master inj_m at cycle inj_t.
   task automatic record_grants(input int ncyc, input int inj_t, input int inj_m);
      logic [N-1:0] prev;
      prev = bus.grant;
      gc.delete();
      gi.delete();
      repeat (ncyc) begin
         tick();
         if (bus.grant != '0 && prev == '0) begin
            gc.push_back(t);
            gi.push_back(onehot_idx(bus.grant));
         end
         prev = bus.grant;
         if (t == inj_t) want[inj_m]++;
      end
   endtask

   task automatic wait_quiet();
      bit ok;
      int n;
      ok = 1'b0;
      for (n = 0; n < 300 && !ok; n++) begin
         @(negedge clk);
         ok = (bus.busy === 1'b0) && all_done();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL quiet: still busy or requests pending after %0d cycles", n);
      end
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int n0;
      int exp_c2 [5] = '{1, 7, 13, 19, 25};
      int exp_i2 [5] = '{0, 1, 2, 3, 0};
      logic [W-1:0] exp_w2 [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
      int exp_c3 [3] = '{1, 7, 13};
      int exp_i3 [3] = '{0, 3, 0};

      rst      = 1'b1;
      slave_on = 1'b1;
      @(posedge clk);
      #1 chk_en = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);

      // reset state
      check("rst_grant", 32'(bus.grant), 32'h0);
      check("rst_s_valid", 32'(bus.s_valid), 32'h0);
      check("rst_s_data", 32'(bus.s_data), 32'h0);
      check("rst_m_ready", 32'(bus.m_ready), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_timeout", 32'(bus.timeout_err), 32'h0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

      // single master 2, data A
      mdata[2] = 4'hA;
      want[2]++;
      start();
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (t == 1) begin
            check("t1_grant", 32'(bus.grant), 32'b0100);
            check("t1_s_data", 32'(bus.s_data), 32'hA);
         end
         if (t == 2) check("t1_m_ready_c2", 32'(bus.m_ready), 32'h0);
         if (t == 3) check("t1_m_ready_c3", 32'(bus.m_ready), 32'b0100);
         if (t == 4 || t == 5) begin
            check("t1_s_valid_gap", 32'(bus.s_valid), 32'h0);
            check("t1_busy_gap", 32'(bus.busy), 32'h1);
         end
         if (t == 6) check("t1_busy_idle", 32'(bus.busy), 32'h0);
      end
      wait_quiet();

      // all four masters; grant starts are 6 cycles apart:
      // 1 to grant, 2 more until ready, 1 transfer cycle, GAP=2 release
      do_reset();
      n0 = log_q.size();
      for (int i = 0; i < N; i++) mdata[i] = W'(i + 1);
      want[0] += 2;
      want[1] += 1;
      want[2] += 1;
      want[3] += 1;
      start();
      record_grants(40, -1, 0);
      check("t2_grant_count", 32'(gc.size()), 32'd5);
      for (int k = 0; k < 5 && k < gc.size(); k++) begin
         check("t2_grant_cycle", 32'(gc[k]), 32'(exp_c2[k]));
         check("t2_grant_idx", 32'(gi[k]), 32'(exp_i2[k]));
      end
      wait_quiet();
      check("t2_word_count", 32'(log_q.size() - n0), 32'd5);
      for (int k = 0; k < 5 && n0 + k < log_q.size(); k++) begin
         check("t2_word", 32'(log_q[n0 + k]), 32'(exp_w2[k]));
      end

      // fairness: master 3 arrives during master 0's grant
      do_reset();
      mdata[0] = 4'h5;
      mdata[3] = 4'h9;
      want[0] += 2;
      start();
      record_grants(25, 2, 3);
      check("t3_grant_count", 32'(gc.size()), 32'd3);
      for (int k = 0; k < 3 && k < gc.size(); k++) begin
         check("t3_grant_cycle", 32'(gc[k]), 32'(exp_c3[k]));
         check("t3_grant_idx", 32'(gi[k]), 32'(exp_i3[k]));
      end
      wait_quiet();

      // watchdog: slave silent, master 1 requesting
      do_reset();
      set_slave(1'b0);
      mdata[1] = 4'h6;
      want[1]++;
      start();
      while (t < 21) begin
         tick();
         if (t >= 1 && t <= 15) check("t4_no_m_ready", 32'(bus.m_ready), 32'h0);
         if (t == 14) check("t4_timeout_c14", 32'(bus.timeout_err), 32'h0);
         if (t == 15) check("t4_timeout_c15", 32'(bus.timeout_err), 32'h1);
         if (t == 16) begin
            check("t4_timeout_c16", 32'(bus.timeout_err), 32'h0);
            check("t4_grant_c16", 32'(bus.grant), 32'h0);
            @(posedge clk);
            #2 slave_on = 1'b1;
         end
         if (t == 18) check("t4_grant_c18", 32'(bus.grant), 32'h0);
         if (t == 19) check("t4_regrant", 32'(bus.grant), 32'b0010);
         if (t == 21) check("t4_m_ready_c21", 32'(bus.m_ready), 32'b0010);
      end
      wait_quiet();

      // granted master drops its request mid-grant
      do_reset();
      mdata[1] = 4'h7;
      mdata[2] = 4'h8;
      want[1]++;
      start();
      tick();
      check("t5_grant_c1", 32'(bus.grant), 32'b0010);
      want[1] = done_cnt[1];
      tick();
      check("t5_grant_c2", 32'(bus.grant), 32'b0010);
      check("t5_m_ready_c2", 32'(bus.m_ready), 32'h0);
      tick();
      check("t5_grant_c3", 32'(bus.grant), 32'h0);
      check("t5_s_valid_c3", 32'(bus.s_valid), 32'h0);
      check("t5_m_ready_c3", 32'(bus.m_ready), 32'h0);
      want[1]++;
      want[2]++;
      tick();
      check("t5_busy_c4", 32'(bus.busy), 32'h1);
      tick();
      check("t5_busy_c5", 32'(bus.busy), 32'h0);
      tick();
      check("t5_next_grant", 32'(bus.grant), 32'b0100);
      wait_quiet();

      // reset pulsed during grant
      do_reset();
      mdata[0] = 4'h3;
      want[0]++;
      start();
      tick();
      check("t6_grant_c1", 32'(bus.grant), 32'b0001);
      @(posedge clk);
      #2 rst = 1'b1;
      tick();
      check("t6_grant_c2", 32'(bus.grant), 32'b0001);
      @(posedge clk);
      #2 rst = 1'b0;
      tick();
      check("t6_grant_c3", 32'(bus.grant), 32'h0);
      check("t6_s_valid_c3", 32'(bus.s_valid), 32'h0);
      check("t6_s_data_c3", 32'(bus.s_data), 32'h0);
      check("t6_m_ready_c3", 32'(bus.m_ready), 32'h0);
      check("t6_busy_c3", 32'(bus.busy), 32'h0);
      check("t6_state_c3", 32'(dbg_state), 32'(ST_IDLE));
      tick();
      check("t6_grant_c4", 32'(bus.grant), 32'b0001);
      tick();
      tick();
      check("t6_m_ready_c6", 32'(bus.m_ready), 32'b0001);
      wait_quiet();

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
